// File: rtl/spi_ram_master.sv
// SPI master for the SPI-slave/RAM pair: serialises one 10-bit command per frame
// on MOSI and, for read-data frames, captures the returned byte from MISO.
module spi_ram_master #(
   parameter int RD_WAIT = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_type,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       MOSI,
   output logic       SS_n,
   input  logic       MISO
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_SEL       = 3'd2;
   localparam logic [2:0] S_SHIFT_OUT = 3'd3;
   localparam logic [2:0] S_WAIT      = 3'd4;
   localparam logic [2:0] S_SHIFT_IN  = 3'd5;
   localparam logic [2:0] S_END       = 3'd6;

   localparam logic [3:0] WAIT_LAST = (RD_WAIT > 0) ? 4'(RD_WAIT - 1) : 4'd0;

   logic [2:0] state, state_nxt;
   logic [3:0] cnt;
   logic [9:0] sreg;
   logic [6:0] rx;
   logic       rd_frame;
   logic       mosi_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      if (cmd_valid) state_nxt = S_START;
         S_START:     state_nxt = S_SEL;
         S_SEL:       state_nxt = S_SHIFT_OUT;
         S_SHIFT_OUT: if (cnt == 4'd9) begin
                         if (!rd_frame)        state_nxt = S_END;
                         else if (RD_WAIT > 0) state_nxt = S_WAIT;
                         else                  state_nxt = S_SHIFT_IN;
                      end
         S_WAIT:      if (cnt == WAIT_LAST) state_nxt = S_SHIFT_IN;
         S_SHIFT_IN:  if (cnt == 4'd7) state_nxt = S_END;
         S_END:       state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state, so MOSI leads the shift
   // register by one bit while SHIFT_OUT is running.
   always_comb begin
      mosi_nxt = 1'b0;
      if (state_nxt == S_SEL || state == S_SEL) mosi_nxt = sreg[9];
      else if (state_nxt == S_SHIFT_OUT)        mosi_nxt = sreg[8];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= 4'd0;
         sreg      <= 10'd0;
         rx        <= 7'd0;
         rd_frame  <= 1'b0;
         SS_n      <= 1'b1;
         MOSI      <= 1'b0;
         cmd_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_data  <= 8'h00;
      end else begin
         state <= state_nxt;
         cnt   <= (state_nxt != state) ? 4'd0 : cnt + 4'd1;
         if (state == S_IDLE && cmd_valid) begin
            sreg     <= {cmd_type, cmd_data};
            rd_frame <= &cmd_type;
            rx       <= 7'd0;
         end else if (state == S_SHIFT_OUT) begin
            sreg <= {sreg[8:0], 1'b0};
         end
         // MISO only reaches state while the slave is driving it
         if (state == S_SHIFT_IN) rx <= {rx[5:0], MISO};
         if (state == S_SHIFT_IN && state_nxt == S_END) rsp_data <= {rx, MISO};
         SS_n      <= (state_nxt == S_IDLE) || (state_nxt == S_END);
         cmd_ready <= (state_nxt == S_IDLE);
         MOSI      <= mosi_nxt;
         rsp_valid <= (state_nxt == S_END) && rd_frame;
      end
   end

endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: behavioural slave/RAM, per-cycle output log and
// a response scoreboard; RD_WAIT=2 and RD_WAIT=0 builds side by side.
module tb_spi_ram_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n = 1'b1;

   logic       cmd_valid = 1'b0, cmd_ready;
   logic [1:0] cmd_type = 2'd0;
   logic [7:0] cmd_data = 8'd0;
   logic       rsp_valid, MOSI, SS_n, MISO;
   logic [7:0] rsp_data;

   logic       c0_valid = 1'b0, c0_ready;
   logic [1:0] c0_type = 2'd0;
   logic [7:0] c0_data = 8'd0;
   logic       rsp0_valid, MOSI0, SS0_n, MISO0;
   logic [7:0] rsp0_data;

   spi_ram_master #(.RD_WAIT(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_type(cmd_type), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
      .rsp_data(rsp_data), .MOSI(MOSI), .SS_n(SS_n), .MISO(MISO));

   spi_ram_master #(.RD_WAIT(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(c0_valid), .cmd_ready(c0_ready),
      .cmd_type(c0_type), .cmd_data(c0_data), .rsp_valid(rsp0_valid),
      .rsp_data(rsp0_data), .MOSI(MOSI0), .SS_n(SS0_n), .MISO(MISO0));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errs = 0, checks = 0;
   bit mon_en = 1'b0;

   logic       log_ss [0:4095];
   logic       log_mosi [0:4095];
   logic       log_rsp [0:4095];
   logic       log_ss0 [0:4095];
   logic       log_rsp0 [0:4095];
   logic       log_rdy [0:4095];
   logic [7:0] log_rd0 [0:4095];

   typedef struct {
      logic [7:0] d;
      int         c;
   } rsp_t;
   rsp_t sb[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // w: 0 SS_n, 1 MOSI, 2 rsp_valid, 3 SS0_n, 4 rsp0_valid, 5 cmd_ready; cycles t+1..t+n, MSB first
   function automatic logic [31:0] vec(input int w, input int t, input int n);
      logic [31:0] v = 32'd0;
      logic b;
      for (int i = 1; i <= n; i++) begin
         case (w)
            0: b = log_ss[t+i];
            1: b = log_mosi[t+i];
            2: b = log_rsp[t+i];
            3: b = log_ss0[t+i];
            4: b = log_rsp0[t+i];
            default: b = log_rdy[t+i];
         endcase
         v = {v[30:0], b};
      end
      return v;
   endfunction

   always @(negedge clk) begin : mon
      rsp_t e;
      log_ss[cyc]   = SS_n;
      log_mosi[cyc] = MOSI;
      log_rsp[cyc]  = rsp_valid;
      log_rdy[cyc]  = cmd_ready;
      log_ss0[cyc]  = SS0_n;
      log_rsp0[cyc] = rsp0_valid;
      log_rd0[cyc]  = rsp0_data;
      if (mon_en) begin
         chk("x_on_outputs", 32'($isunknown({SS_n, MOSI, cmd_ready, rsp_valid, rsp_data,
                                            SS0_n, MOSI0, c0_ready, rsp0_valid, rsp0_data})), 32'd0);
         if (rsp_valid) begin
            if (sb.size() == 0) chk("rsp_unexpected", 32'(sb.size()), 32'd1);
            else begin
               e = sb.pop_front();
               chk("rsp_data", 32'(rsp_data), 32'(e.d));
               chk("rsp_cycle", 32'(cyc), 32'(e.c));
            end
         end
      end
   end

   // Behavioural slave/RAM: frame cycle 1 is START, bits arrive in cycles 3..12
   logic [7:0] mem [0:255];
   logic [7:0] wa = 8'd0, ra = 8'd0, txb = 8'd0;
   logic [9:0] rxb = 10'd0;
   int  scnt = 0;
   bit  rd_act = 1'b0, force_en = 1'b0;
   initial foreach (mem[i]) mem[i] = 8'd0;

   always @(negedge clk) begin
      if (SS_n !== 1'b0) begin
         scnt = 0; rd_act = 1'b0; MISO = 1'bx;
      end else begin
         scnt++;
         if (scnt >= 3 && scnt <= 12) rxb = {rxb[8:0], MOSI};
         if (scnt == 12) begin
            case (rxb[9:8])
               2'b00: wa = rxb[7:0];
               2'b01: mem[wa] = rxb[7:0];
               2'b10: ra = rxb[7:0];
               default: begin
                  txb = force_en ? 8'hB2 : mem[ra];
                  rd_act = 1'b1;
               end
            endcase
         end
         MISO = (rd_act && scnt >= 15 && scnt <= 22) ? txb[22-scnt] : 1'bx;
      end
   end

   logic [7:0] tx0 = 8'h5A;
   int scnt0 = 0;
   always @(negedge clk) begin
      if (SS0_n !== 1'b0) begin
         scnt0 = 0; MISO0 = 1'bx;
      end else begin
         scnt0++;
         MISO0 = (scnt0 >= 13 && scnt0 <= 20) ? tx0[20-scnt0] : 1'bx;
      end
   end

   task automatic send(input logic [1:0] ty, input logic [7:0] d, input bit keep, output int t);
      int n = 0;
      cmd_type = ty; cmd_data = d; cmd_valid = 1'b1; t = -1;
      while (t < 0 && n < 64) begin
         if (cmd_ready === 1'b1) t = cyc;
         else begin @(negedge clk); n++; end
      end
      if (t < 0) begin
         chk("accept_timeout", 32'(n), 32'd0);
         cmd_valid = 1'b0; t = cyc;
      end else begin
         @(posedge clk); #1;
         cmd_valid = keep; cmd_data = ~d;
         @(negedge clk);
      end
   endtask

   task automatic wait_to(input int c);
      int n = 0;
      while (cyc < c && n < 1000) begin @(negedge clk); n++; end
   endtask

   initial begin
      int t, t0;
      int ta[4];
      logic [1:0] ty;
      logic [7:0] dv [4] = '{8'h96, 8'h69, 8'hC3, 8'h1E};

      #1 rst_n = 1'b0;
      #12;
      chk("reset_state", 32'({SS_n, MOSI, cmd_ready, rsp_valid, rsp_data}), 32'hA00);
      chk("reset_state0", 32'({SS0_n, MOSI0, c0_ready, rsp0_valid, rsp0_data}), 32'hA00);
      @(negedge clk) rst_n = 1'b1;
      mon_en = 1'b1;
      repeat (2) @(negedge clk);

      // reset in the middle of a write-data frame
      send(2'b01, 8'hFF, 1'b0, t);
      wait_to(t + 7);
      chk("pre_rst_shift", 32'({SS_n, MOSI}), 32'h1);
      #2 rst_n = 1'b0;
      #1 chk("mid_rst_async", 32'({SS_n, MOSI, cmd_ready, rsp_valid, rsp_data}), 32'hA00);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_no_rsp", vec(2, t, 10), 32'd0);

      // write-addr A5
      send(2'b00, 8'hA5, 1'b0, t);
      wait_to(t + 15);
      chk("wa_ss", vec(0, t, 14), 32'h3);
      chk("wa_mosi", vec(1, t + 1, 11), 32'h0A5);
      chk("wa_ready", vec(5, t, 14), 32'h1);
      chk("wa_no_rsp", vec(2, t, 14), 32'd0);

      // write-data 3C, read-addr A5, read-data through the slave/RAM
      send(2'b01, 8'h3C, 1'b0, t);
      wait_to(t + 14);
      chk("wd_mosi", vec(1, t + 1, 11), 32'h13C);
      send(2'b10, 8'hA5, 1'b0, t);
      wait_to(t + 14);
      send(2'b11, 8'h00, 1'b0, t);
      sb.push_back('{8'h3C, t + 23});
      wait_to(t + 24);
      chk("rd_ss", vec(0, t, 23), 32'd1);
      chk("rd_rsp_once", vec(2, t, 23), 32'd1);
      chk("rd_sb_drained", 32'(sb.size()), 32'd0);

      // forced MISO pattern, X outside the capture window
      force_en = 1'b1;
      send(2'b11, 8'h00, 1'b0, t);
      sb.push_back('{8'hB2, t + 23});
      wait_to(t + 24);
      force_en = 1'b0;
      chk("frc_mosi", vec(1, t + 1, 11), 32'h700);
      chk("frc_sb_drained", 32'(sb.size()), 32'd0);

      // RD_WAIT=0 build
      chk("rw0_ready", 32'(c0_ready), 32'd1);
      c0_type = 2'b11; c0_data = 8'h00; c0_valid = 1'b1;
      t0 = cyc;
      @(posedge clk); #1 c0_valid = 1'b0;
      @(negedge clk);
      wait_to(t0 + 23);
      chk("rw0_ss", vec(3, t0, 21), 32'd1);
      chk("rw0_rsp_at_21", vec(4, t0, 22), 32'd2);
      chk("rw0_data", 32'(log_rd0[t0 + 21]), 32'h5A);

      // cmd_valid held high, alternating write-addr / write-data
      for (int i = 0; i < 4; i++) begin
         ty = (i % 2 == 1) ? 2'b01 : 2'b00;
         send(ty, dv[i], (i < 3), ta[i]);
      end
      wait_to(ta[3] + 15);
      for (int i = 0; i < 4; i++) begin
         ty = (i % 2 == 1) ? 2'b01 : 2'b00;
         chk("b2b_ss", vec(0, ta[i], 14), 32'h3);
         chk("b2b_mosi", vec(1, ta[i] + 1, 11), 32'({ty[1], ty, dv[i]}));
         if (i > 0) chk("b2b_period", 32'(ta[i] - ta[i-1]), 32'd14);
      end

      chk("sb_final", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
